// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK sample.
// Optional build macro PS2_TX_RETRY_EN resends a failed byte up to two more times.
module ps2_host_tx #(
  parameter int FREQ_HZ          = 25_000_000,
  parameter int INHIBIT_US       = 100,
  parameter int START_TIMEOUT_MS = 15,
  parameter int FRAME_TIMEOUT_MS = 2
) (
  input  logic       clk_cpu,
  input  logic       reset_n_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       ps2clk_i,
  input  logic       ps2dat_i,
  output logic       ps2clk_oe_o,
  output logic       ps2dat_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] status_o,
  output logic [2:0] dbg_state
);

  // Handshake: a byte transfers on a cycle where valid_i && ready_o; ready_o is high
  // only in IDLE, so valid_i during a frame is ignored and nothing is queued.

  localparam int INH  = FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int TS   = FREQ_HZ / 1000 * START_TIMEOUT_MS;
  localparam int TF   = FREQ_HZ / 1000 * FRAME_TIMEOUT_MS;
  localparam int CMAX = (INH > TS) ? ((INH > TF) ? INH : TF) : ((TS > TF) ? TS : TF);
  localparam int CW   = $clog2(CMAX + 1);

  // The RTS cycle is the last cycle of the inhibit time, hence INH-1 in INHIBIT.
  localparam logic [CW-1:0] INH_LOAD = CW'((INH > 1) ? INH - 1 : 1);
  localparam logic [CW-1:0] TS_LOAD  = CW'(TS);
  localparam logic [CW-1:0] TF_LOAD  = CW'(TF);

  localparam logic [1:0] ST_ACK      = 2'b00;
  localparam logic [1:0] ST_NACK     = 2'b01;
  localparam logic [1:0] ST_START_TO = 2'b10;
  localparam logic [1:0] ST_FRAME_TO = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_WAIT_CLK  = 3'd3,
    S_SHIFT     = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n, cnt_dec;
  logic [9:0]    shreg_q, shreg_n;
  logic [3:0]    edges_q, edges_n;
  logic          drive_q, drive_n;
  logic [1:0]    status_q, status_n;
  logic [7:0]    byte_q, byte_n;
  logic          attempt_fail;
  logic          expire;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    retry_q, retry_n;
`endif

  logic clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
  logic fall;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk_cpu or negedge reset_n_i) begin
    if (!reset_n_i) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2clk_i;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2dat_i;
      dat_sync <= dat_meta;
    end
  end

  assign fall    = clk_prev & ~clk_sync;
  assign expire  = (cnt_q <= CW'(1));
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CW'(1);

  always_ff @(posedge clk_cpu or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '1;
      edges_q  <= '0;
      drive_q  <= 1'b0;
      status_q <= ST_ACK;
      byte_q   <= '0;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      shreg_q  <= shreg_n;
      edges_q  <= edges_n;
      drive_q  <= drive_n;
      status_q <= status_n;
      byte_q   <= byte_n;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= retry_n;
`endif
    end
  end

  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    shreg_n      = shreg_q;
    edges_n      = edges_q;
    drive_n      = drive_q;
    status_n     = status_q;
    byte_n       = byte_q;
    attempt_fail = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_n      = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          byte_n  = data_i;
          cnt_n   = INH_LOAD;
          drive_n = 1'b0;
          state_n = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_n = '0;
`endif
        end
      end
      S_INHIBIT: begin
        cnt_n = cnt_dec;
        if (expire) state_n = S_RTS;
      end
      S_RTS: begin
        shreg_n = {1'b1, ~^byte_q, byte_q};
        cnt_n   = TS_LOAD;
        state_n = S_WAIT_CLK;
      end
      S_WAIT_CLK: begin
        if (fall) begin
          drive_n = ~shreg_q[0];
          shreg_n = {1'b1, shreg_q[9:1]};
          edges_n = 4'd1;
          cnt_n   = TF_LOAD;
          state_n = S_SHIFT;
        end else if (expire) begin
          status_n     = ST_START_TO;
          attempt_fail = 1'b1;
        end else begin
          cnt_n = cnt_dec;
        end
      end
      S_SHIFT: begin
        cnt_n = cnt_dec;
        // Edge before expiry: a late last edge still completes the frame.
        if (fall) begin
          if (edges_q == 4'd10) begin
            status_n = dat_sync ? ST_NACK : ST_ACK;
            drive_n  = 1'b0;
            state_n  = S_WAIT_IDLE;
          end else begin
            drive_n = ~shreg_q[0];
            shreg_n = {1'b1, shreg_q[9:1]};
            edges_n = edges_q + 4'd1;
          end
        end else if (expire) begin
          drive_n      = 1'b0;
          status_n     = ST_FRAME_TO;
          attempt_fail = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        cnt_n = cnt_dec;
        if (clk_sync && dat_sync) begin
          if (status_q == ST_ACK) state_n = S_DONE;
          else                    attempt_fail = 1'b1;
        end else if (expire) begin
          status_n     = ST_FRAME_TO;
          attempt_fail = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (attempt_fail) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_n = retry_q + 2'd1;
        cnt_n   = INH_LOAD;
        drive_n = 1'b0;
        state_n = S_INHIBIT;
      end else begin
        state_n = S_DONE;
      end
`else
      state_n = S_DONE;
`endif
    end
  end

  // Outputs decode the state register directly, so reset releases the lines at once.
  assign ps2clk_oe_o = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign ps2dat_oe_o = (state_q == S_RTS) || (state_q == S_WAIT_CLK) ||
                       ((state_q == S_SHIFT) && drive_q);
  assign ready_o     = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign status_o    = status_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and a scoreboard.
module tb_ps2_host_tx;

  localparam int FREQ = 1_000_000;
  localparam int INH  = 100;
  localparam int TS   = 15_000;
  localparam int TF   = 2_000;
  localparam int H    = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid = 1'b0;
  logic       ready, busy, done;
  logic       ps2clk_oe, ps2dat_oe;
  logic [1:0] status;
  logic [2:0] dbg_state;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2clk_pin, ps2dat_pin;

  assign ps2clk_pin = ~(ps2clk_oe | dev_clk_low);
  assign ps2dat_pin = ~(ps2dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .FREQ_HZ(FREQ), .INHIBIT_US(100), .START_TIMEOUT_MS(15), .FRAME_TIMEOUT_MS(2)
  ) dut (
    .clk_cpu(clk), .reset_n_i(reset_n), .data_i(data_in), .valid_i(valid),
    .ready_o(ready), .ps2clk_i(ps2clk_pin), .ps2dat_i(ps2dat_pin),
    .ps2clk_oe_o(ps2clk_oe), .ps2dat_oe_o(ps2dat_oe), .busy_o(busy),
    .done_o(done), .status_o(status), .dbg_state(dbg_state)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int inh_cnt = 0;
  int first_edge_cyc = 0;
  logic prev_clk_oe = 1'b0;

  logic [10:0] exp_q[$];
  logic [1:0]  stat_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_clk_oe <= ps2clk_oe;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (valid === 1'b1 && ready === 1'b1) acc_cnt <= acc_cnt + 1;
    if (ps2clk_oe === 1'b1 && prev_clk_oe === 1'b0) inh_cnt <= inh_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic hold);
    int g = 0;
    while (ready !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    check("ready_before_send", 32'(ready), 1);
    data_in = b;
    valid = 1'b1;
    tick();
    if (!hold) valid = 1'b0;
  endtask

  task automatic measure_inhibit(output int n);
    n = 0;
    while (ps2clk_oe === 1'b1 && n < INH + 50) begin
      n++;
      tick();
    end
  endtask

  // Device side: wait for request-to-send, clock the frame, sample host bits at end of low.
  task automatic dev_frame(input int n_edges, input logic ack, output logic [10:0] bits);
    int g = 0;
    bits = '1;
    while (!(busy === 1'b1 && ps2clk_oe === 1'b0 && ps2dat_oe === 1'b1) && g < 2000) begin
      tick();
      g++;
    end
    repeat (5) tick();
    bits[0] = ps2dat_pin;
    first_edge_cyc = cyc;
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 11) dev_dat_low = ack;
      dev_clk_low = 1'b1;
      repeat (H) tick();
      if (i <= 10) bits[i] = ps2dat_pin;
      dev_clk_low = 1'b0;
      if (i < 11) repeat (H) tick();
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done), 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    int n;
    int d0, a0, i0, diff;

    repeat (3) tick();
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_status", 32'(status), 0);
    check("rst_lines", 32'({ps2clk_oe, ps2dat_oe}), 0);
    reset_n = 1'b1;
    repeat (2) tick();
    check("idle_ready", 32'(ready), 1);

    // 0xF4 with ACK
    exp_q.push_back(11'b1_0_11110100_0);
    stat_q.push_back(2'b00);
    send_byte(8'hF4, 1'b0);
    check("f4_busy", 32'(busy), 1);
    check("f4_ready_low", 32'(ready), 0);
    measure_inhibit(n);
    check("f4_inhibit_cycles", 32'(n), INH);
    dev_frame(11, 1'b1, bits);
    check("f4_wire_bits", 32'(bits), 32'(exp_q.pop_front()));
    wait_done(100, n);
    check("f4_status", 32'(status), 32'(stat_q.pop_front()));
    check("f4_lines_released", 32'({ps2clk_oe, ps2dat_oe}), 0);
    tick();
    check("f4_ready_back", 32'(ready), 1);

    // 0x00: odd parity puts a 1 on the wire
    exp_q.push_back(11'b1_1_00000000_0);
    stat_q.push_back(2'b00);
    send_byte(8'h00, 1'b0);
    measure_inhibit(n);
    dev_frame(11, 1'b1, bits);
    check("z_wire_bits", 32'(bits), 32'(exp_q.pop_front()));
    wait_done(100, n);
    check("z_status", 32'(status), 32'(stat_q.pop_front()));

`ifndef PS2_TX_RETRY_EN
    // NACK: device leaves data high on the ACK edge
    exp_q.push_back(11'b1_1_01011010_0);
    stat_q.push_back(2'b01);
    send_byte(8'h5A, 1'b0);
    measure_inhibit(n);
    dev_frame(11, 1'b0, bits);
    check("nack_wire_bits", 32'(bits), 32'(exp_q.pop_front()));
    wait_done(100, n);
    check("nack_status", 32'(status), 32'(stat_q.pop_front()));
    repeat (3) tick();
    check("nack_lines_released", 32'({ps2clk_oe, ps2dat_oe}), 0);

    // Start timeout: device never clocks
    stat_q.push_back(2'b10);
    send_byte(8'h11, 1'b0);
    measure_inhibit(n);
    check("sto_inhibit_cycles", 32'(n), INH);
    n = 0;
    while (done !== 1'b1 && n < TS + 100) begin
      tick();
      n++;
    end
    check("sto_done_seen", 32'(done), 1);
    check_range("sto_cycles", n, TS - 3, TS + 3);
    check("sto_status", 32'(status), 32'(stat_q.pop_front()));
    check("sto_lines_released", 32'({ps2clk_oe, ps2dat_oe}), 0);

    // Frame timeout: device stops after 5 edges
    stat_q.push_back(2'b11);
    send_byte(8'h22, 1'b0);
    measure_inhibit(n);
    dev_frame(5, 1'b1, bits);
    wait_done(TF + 200, n);
    diff = cyc - first_edge_cyc;
    check_range("fto_cycles", diff, TF - 3, TF + 3);
    check("fto_status", 32'(status), 32'(stat_q.pop_front()));
    check("fto_lines_released", 32'({ps2clk_oe, ps2dat_oe}), 0);
`endif

    // Reset during edge 4 of 0x00: bit 3 is 0, so data is being driven low
    send_byte(8'h00, 1'b0);
    measure_inhibit(n);
    dev_frame(3, 1'b1, bits);
    dev_clk_low = 1'b1;
    repeat (5) tick();
    check("rst_mid_dat_driven", 32'(ps2dat_oe), 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_mid_lines_released", 32'({ps2clk_oe, ps2dat_oe}), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    dev_clk_low = 1'b0;
    repeat (20) tick();
    check("rst_mid_no_done", 32'(done_cnt - d0), 0);
    check("rst_mid_ready", 32'(ready), 1);

    // valid_i held across the whole frame: exactly one accept
    exp_q.push_back(11'b1_1_10100101_0);
    stat_q.push_back(2'b00);
    a0 = acc_cnt;
    i0 = inh_cnt;
    send_byte(8'hA5, 1'b1);
    measure_inhibit(n);
    dev_frame(11, 1'b1, bits);
    check("held_wire_bits", 32'(bits), 32'(exp_q.pop_front()));
    wait_done(100, n);
    valid = 1'b0;
    check("held_status", 32'(status), 32'(stat_q.pop_front()));
    repeat (3) tick();
    check("held_accepts", 32'(acc_cnt - a0), 1);
    check("held_inhibits", 32'(inh_cnt - i0), 1);

`ifdef PS2_TX_RETRY_EN
    // NACK then ACK: two inhibit phases, one done with status 00
    exp_q.push_back(11'b1_1_00111100_0);
    exp_q.push_back(11'b1_1_00111100_0);
    stat_q.push_back(2'b00);
    d0 = done_cnt;
    i0 = inh_cnt;
    send_byte(8'h3C, 1'b0);
    dev_frame(11, 1'b0, bits);
    check("retry_bits_1", 32'(bits), 32'(exp_q.pop_front()));
    check("retry_no_done_yet", 32'(done_cnt - d0), 0);
    dev_frame(11, 1'b1, bits);
    check("retry_bits_2", 32'(bits), 32'(exp_q.pop_front()));
    wait_done(100, n);
    check("retry_status", 32'(status), 32'(stat_q.pop_front()));
    repeat (3) tick();
    check("retry_done_pulses", 32'(done_cnt - d0), 1);
    check("retry_inhibits", 32'(inh_cnt - i0), 2);
`endif

    check("scoreboard_empty", 32'(exp_q.size() + stat_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
